// File: rtl/operand_unpack.sv
// operand_unpack: FPU input stage. Splits a packed IEEE-754 single-precision word into sign,
// unbiased two's-complement exponent, 24-bit mantissa with explicit hidden bit and a 2-bit
// special-case flag. Subnormals are normalised one left shift per cycle, so every result
// leaves with m[23]=1 unless it is a zero or an infinity.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   a holds an operand
//   in_ready   block can accept an operand this cycle
//   a          packed operand {sign, exp[7:0], frac[22:0]}
//   out_valid  s/e/m/flag hold a completed result
//   out_ready  downstream accepts the result this cycle
//   s          sign
//   e          unbiased exponent, EXP_OUT_W-bit two's complement
//   m          mantissa, m[23] = hidden bit
//   flag       00 normal/subnormal, 01 zero, 10 infinity, 11 NaN
//   busy       high while normalising a subnormal
module operand_unpack #(
   parameter int unsigned BIAS      = 127,
   parameter int unsigned EXP_OUT_W = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          a,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 s,
   output logic [EXP_OUT_W-1:0] e,
   output logic [23:0]          m,
   output logic [1:0]           flag,
   output logic                 busy
);

   typedef enum logic [1:0] {StIdle, StNorm, StHold} state_e;

   localparam logic [EXP_OUT_W-1:0] ExpBias = EXP_OUT_W'(BIAS);
   localparam logic [EXP_OUT_W-1:0] ExpInf  = EXP_OUT_W'(128);
   localparam logic [EXP_OUT_W-1:0] ExpSubn = EXP_OUT_W'(-126);
   localparam logic [EXP_OUT_W-1:0] ExpOne  = EXP_OUT_W'(1);

   state_e               state_q;
   logic                 s_q;
   logic [EXP_OUT_W-1:0] e_q;
   logic [23:0]          m_q;
   logic [1:0]           flag_q;

   logic [7:0]           exp_f;
   logic [22:0]          frac_f;
   logic [EXP_OUT_W-1:0] dec_e;
   logic [23:0]          dec_m;
   logic [1:0]           dec_flag;
   logic                 dec_subn;
   logic                 accept;

   assign exp_f  = a[30:23];
   assign frac_f = a[22:0];

   assign in_ready  = (state_q == StIdle) | ((state_q == StHold) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == StHold);
   assign busy      = (state_q == StNorm);
   assign s         = s_q;
   assign e         = e_q;
   assign m         = m_q;
   assign flag      = flag_q;

   // Field decode of the incoming operand.
   always_comb begin
      dec_e    = EXP_OUT_W'(exp_f) - ExpBias;
      dec_m    = {1'b1, frac_f};
      dec_flag = 2'b00;
      dec_subn = 1'b0;
      if (exp_f == 8'h00) begin
         if (frac_f == 23'd0) begin
            dec_e    = '0;
            dec_m    = '0;
            dec_flag = 2'b01;
         end else begin
            // Subnormal: start at the minimum normal exponent, normalised in StNorm.
            dec_e    = ExpSubn;
            dec_m    = {1'b0, frac_f};
            dec_subn = 1'b1;
         end
      end else if (exp_f == 8'hFF) begin
         dec_e = ExpInf;
         if (frac_f == 23'd0) begin
            dec_m    = '0;
            dec_flag = 2'b10;
         end else begin
            // NaN payload kept as-is; quiet bit is not forced.
            dec_flag = 2'b11;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         s_q     <= 1'b0;
         e_q     <= '0;
         m_q     <= '0;
         flag_q  <= 2'b00;
      end else if (accept) begin
         s_q     <= a[31];
         e_q     <= dec_e;
         m_q     <= dec_m;
         flag_q  <= dec_flag;
         state_q <= dec_subn ? StNorm : StHold;
      end else begin
         case (state_q)
            StNorm: begin
               m_q <= {m_q[22:0], 1'b0};
               e_q <= e_q - ExpOne;
               // The shift about to happen brings a one into the hidden-bit position.
               if (m_q[22]) state_q <= StHold;
            end
            StHold: begin
               if (out_ready) state_q <= StIdle;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_unpack.sv
// Directed self-checking bench for operand_unpack.
module tb_operand_unpack;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic        out_valid;
   logic        out_ready;
   logic        s;
   logic [9:0]  e;
   logic [23:0] m;
   logic [1:0]  flag;
   logic        busy;

   int checks;
   int errors;
   bit rand_phase;

   operand_unpack #(
      .BIAS      (127),
      .EXP_OUT_W (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .e         (e),
      .m         (m),
      .flag      (flag),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Any result with a special flag during the random-normal phase is an error.
   always @(negedge clk) begin
      if (rand_phase && out_valid === 1'b1) begin
         checks++;
         if (flag !== 2'b00) begin
            errors++;
            $display("FAIL rand_flag_monitor: flag=%b required 00", flag);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 32'h3F800000; out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid, s, e, m, flag, busy} !== 39'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0", {out_valid, s, e, m, flag, busy});
      end
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || m !== 24'd0) begin
         errors++;
         $display("FAIL reset_ignores_in_valid: out_valid=%b m=%h required 0/0", out_valid, m);
      end
      in_valid = 1'b0;
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_normal();
      out_ready = 1'b1; in_valid = 1'b1; a = 32'h3F800000;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, s, e, m, flag} !== {1'b1, 1'b0, 10'd0, 24'h800000, 2'b00}) begin
         errors++;
         $display("FAIL normal_one: got v=%b s=%b e=%h m=%h f=%b required 1 0 000 800000 00",
                  out_valid, s, e, m, flag);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || e !== 10'd0 || m !== 24'h800000) begin
         errors++;
         $display("FAIL normal_release: v=%b e=%h m=%h required 0 000 800000", out_valid, e, m);
      end
   endtask

   task automatic test_subnormal(input logic [31:0] op, input int k, input logic [9:0] exp_e);
      int lat;
      int busy_cnt;
      out_ready = 1'b1; in_valid = 1'b1; a = op;
      tick();
      in_valid = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (out_valid !== 1'b1 && lat < 64) begin
         if (busy === 1'b1) busy_cnt++;
         if (in_ready !== 1'b0) begin
            checks++; errors++;
            $display("FAIL subn_in_ready: in_ready=%b required 0 during NORM", in_ready);
         end
         tick();
         lat++;
      end
      checks++;
      if (lat != 1 + k || busy_cnt != k) begin
         errors++;
         $display("FAIL subn_latency a=%h: latency=%0d busy=%0d required %0d/%0d",
                  op, lat, busy_cnt, 1 + k, k);
      end
      checks++;
      if ({out_valid, busy, e, m, flag} !== {1'b1, 1'b0, exp_e, 24'h800000, 2'b00}) begin
         errors++;
         $display("FAIL subn_result a=%h: v=%b busy=%b e=%h m=%h f=%b required 1 0 %h 800000 00",
                  op, out_valid, busy, e, m, flag, exp_e);
      end
      tick();
   endtask

   task automatic test_back_to_back_specials();
      logic [31:0] ops [3];
      logic [37:0] exp_v [3];
      ops[0] = 32'h80000000; exp_v[0] = {1'b1, 1'b1, 10'd0,   24'h000000, 2'b01};
      ops[1] = 32'h7F800000; exp_v[1] = {1'b1, 1'b0, 10'd128, 24'h000000, 2'b10};
      ops[2] = 32'hFFC00001; exp_v[2] = {1'b1, 1'b1, 10'd128, 24'hC00001, 2'b11};
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = ops[i];
         tick();
         checks++;
         if ({out_valid, s, e, m, flag} !== exp_v[i]) begin
            errors++;
            $display("FAIL special_%0d a=%h: got %h required %h",
                     i, ops[i], {out_valid, s, e, m, flag}, exp_v[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL special_drain: out_valid=%b required 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_valid = 1'b1; a = 32'h40490FDB;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid, in_ready, s, e, m, flag} !==
             {1'b1, 1'b0, 1'b0, 10'd1, 24'hC90FDB, 2'b00}) begin
            errors++;
            $display("FAIL bp_hold_%0d: v=%b rdy=%b s=%b e=%h m=%h f=%b required 1 0 0 001 c90fdb 00",
                     i, out_valid, in_ready, s, e, m, flag);
         end
         tick();
      end
      out_ready = 1'b1; in_valid = 1'b1; a = 32'hC0000000;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_in_ready: in_ready=%b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, s, e, m, flag} !== {1'b1, 1'b1, 10'd1, 24'h800000, 2'b00}) begin
         errors++;
         $display("FAIL bp_next: v=%b s=%b e=%h m=%h f=%b required 1 1 001 800000 00",
                  out_valid, s, e, m, flag);
      end
      tick();
   endtask

   task automatic test_reset_mid_norm();
      out_ready = 1'b1; in_valid = 1'b1; a = 32'h00000001;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rstnorm_busy_before: busy=%b required 1", busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, s, e, m, flag, busy} !== 39'd0) begin
         errors++;
         $display("FAIL rstnorm_async: got %h required 0", {out_valid, s, e, m, flag, busy});
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid !== 1'b0) begin
            checks++; errors++;
            $display("FAIL rstnorm_presented: out_valid=%b required 0", out_valid);
         end
         tick();
      end
      in_valid = 1'b1; a = 32'h3F800000;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, s, e, m, flag} !== {1'b1, 1'b0, 10'd0, 24'h800000, 2'b00}) begin
         errors++;
         $display("FAIL rstnorm_recover: v=%b e=%h m=%h f=%b required 1 000 800000 00",
                  out_valid, e, m, flag);
      end
      tick();
   endtask

   task automatic test_random_normals();
      logic [31:0] op;
      logic [9:0]  eb;
      out_ready = 1'b1;
      rand_phase = 1'b1;
      for (int i = 0; i < 24; i++) begin
         op = $urandom;
         op[30:23] = 8'($urandom_range(1, 254));
         in_valid = 1'b1; a = op;
         tick();
         eb = e + 10'd127;
         checks++;
         if (out_valid !== 1'b1 || m[23] !== 1'b1 || {s, eb[7:0], m[22:0]} !== op) begin
            errors++;
            $display("FAIL rand_%0d a=%h: v=%b reassembled=%h m23=%b",
                     i, op, out_valid, {s, eb[7:0], m[22:0]}, m[23]);
         end
      end
      in_valid = 1'b0;
      tick();
      rand_phase = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rand_phase = 1'b0;
      test_reset();
      test_normal();
      test_subnormal(32'h00000001, 23, 10'h36B);
      test_subnormal(32'h00400000, 1, 10'h381);
      test_back_to_back_specials();
      test_backpressure();
      test_reset_mid_norm();
      test_random_normals();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
